// File: rtl/line_mem_bridge_pkg.sv
// ---------------------------------------------------------------------------
// line_mem_pkg
// Shared constants and types for the cache-line to SRAM bridge.
//   state_e        : bridge FSM states
//   WORDS_PER_LINE : 32-bit words per cache line
//   BEAT_W         : width of the beat counter (one beat per word)
//   WORD_W/LINE_W  : word and line widths of the CacheMem bus
//   WORD_BE_W/LINE_BE_W : byte-enable widths for a word and a line
// ---------------------------------------------------------------------------
package line_mem_pkg;

    localparam int WORDS_PER_LINE = 4;
    localparam int BEAT_W         = 2;
    localparam int WORD_W         = 32;
    localparam int LINE_W         = WORD_W * WORDS_PER_LINE;
    localparam int WORD_BE_W      = WORD_W / 8;
    localparam int LINE_BE_W      = LINE_W / 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD   = 3'd2,
        RDW  = 3'd3,
        RSP  = 3'd4
    } state_e;

endpackage

// File: rtl/line_mem_bridge_if.sv
// ---------------------------------------------------------------------------
// line_mem_bridge_if
// Cache-line memory bus (CacheMem style) between the cache refill port and
// the line memory.
//   i_addr          : byte address, line aligned (bits [3:0] ignored)
//   i_byte_en       : per-byte write enables, bit n = line byte n
//   i_writedata     : write line
//   i_read/i_write  : request strobes
//   o_readdata      : read line
//   o_readdata_valid: one-cycle pulse qualifying o_readdata
//   o_waitrequest   : high = request not accepted this cycle
//
// Handshake: a request (i_read or i_write) is taken on any rising edge where
// o_waitrequest is low. While o_waitrequest is high the master must hold the
// request and its payload stable. Read data returns later as a single
// o_readdata_valid pulse; there is no back-pressure on the response.
//
// Modports: master = cache side, slave = memory side.
// ---------------------------------------------------------------------------
interface line_mem_bridge_if
    import line_mem_pkg::*;
#(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0]    i_addr;
    logic [LINE_BE_W-1:0] i_byte_en;
    logic [LINE_W-1:0]    i_writedata;
    logic                 i_read;
    logic                 i_write;
    logic [LINE_W-1:0]    o_readdata;
    logic                 o_readdata_valid;
    logic                 o_waitrequest;

    modport master (
        output i_addr, i_byte_en, i_writedata, i_read, i_write,
        input  o_readdata, o_readdata_valid, o_waitrequest
    );

    modport slave (
        input  i_addr, i_byte_en, i_writedata, i_read, i_write,
        output o_readdata, o_readdata_valid, o_waitrequest
    );
endinterface

// File: rtl/line_mem_bridge.sv
// ---------------------------------------------------------------------------
// line_mem_bridge
// Cache-line bus slave backed by a single-port synchronous SRAM (1-cycle
// read latency). Each 128-bit line transfer is serialised into four 32-bit
// beats.
//
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : line_mem_bridge_if.slave (address, byte enables, write
//                line, read/write, read line, readdata_valid, waitrequest)
//   o_err      : sticky error, set when read and write arrive together
//   sram_*     : SRAM strobe, write, word address, byte enables, write
//                word, and read word (valid the cycle after a read strobe)
//
// Build option:
//   LINE_MEM_WR_SKIP_EN : when defined, write beats whose byte-enable slice
//                         is all zero do not strobe the SRAM (timing kept).
//
// Timing: write = 4 busy cycles after acceptance; read data valid in the
// sixth cycle after the accepting edge (4 issue beats, 1 drain, 1 response).
// ---------------------------------------------------------------------------
module line_mem_bridge
    import line_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128,
    parameter int MEM_AW = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    line_mem_bridge_if.slave     bus,
    output logic                 o_err,
    output logic                 sram_en,
    output logic                 sram_we,
    output logic [MEM_AW-1:0]    sram_addr,
    output logic [WORD_BE_W-1:0] sram_be,
    output logic [WORD_W-1:0]    sram_wdata,
    input  logic [WORD_W-1:0]    sram_rdata
);

    if (LINE_W != WORDS_PER_LINE * WORD_W) begin : g_bad_line_w
        $error("line_mem_bridge supports only 4-word lines");
    end

    // The SRAM word address is MEM_AW bits; the low BEAT_W bits select the
    // word within the line, so the stored line index is the rest.
    localparam int LINE_IDX_W = MEM_AW - BEAT_W;

    state_e                  state_q, state_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic [LINE_IDX_W-1:0]   line_q, line_d;
    logic [LINE_BE_W-1:0]    be_q, be_d;
    logic [LINE_W-1:0]       wd_q, wd_d;
    logic [LINE_W-1:0]       buf_q, buf_d;
    logic [LINE_W-1:0]       rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic [ADDR_W-1:0]       addr;
    logic [BEAT_W-1:0]       cap_idx;
    logic                    unused_addr_bits;

    assign addr             = bus.i_addr;
    assign unused_addr_bits = ^{addr[ADDR_W-1:MEM_AW+2], addr[3:0]};

    // Read word k arrives one cycle after its issue, i.e. while the counter
    // already shows k+1. In RDW the counter has wrapped to 0, giving slot 3.
    assign cap_idx = beat_q - 2'd1;

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            line_q  <= '0;
            be_q    <= '0;
            wd_q    <= '0;
            buf_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            line_q  <= line_d;
            be_q    <= be_d;
            wd_q    <= wd_d;
            buf_q   <= buf_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        line_d  = line_q;
        be_d    = be_q;
        wd_d    = wd_q;
        buf_d   = buf_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        if ((state_q == RD && beat_q != '0) || state_q == RDW) begin
            buf_d[{cap_idx, 5'b0} +: WORD_W] = sram_rdata;
        end

        case (state_q)
            IDLE: begin
                if (bus.i_read || bus.i_write) begin
                    line_d = addr[MEM_AW+1:4];
                    be_d   = bus.i_byte_en;
                    wd_d   = bus.i_writedata;
                    beat_d = '0;
                    // Write wins a simultaneous read; the read is dropped.
                    state_d = bus.i_write ? WR : RD;
                end
                if (bus.i_read && bus.i_write) begin
                    err_d = 1'b1;
                end
            end
            WR: begin
                beat_d = beat_q + 2'd1;
                if (beat_q == 2'd3) state_d = IDLE;
            end
            RD: begin
                beat_d = beat_q + 2'd1;
                if (beat_q == 2'd3) state_d = RDW;
            end
            RDW: begin
                // Output line is held in its own register so it stays stable
                // while the next read refills the buffer.
                rdata_d = buf_d;
                state_d = RSP;
            end
            RSP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        sram_en    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_be    = '0;
        sram_wdata = '0;

        case (state_q)
            WR: begin
                sram_addr  = {line_q, beat_q};
                sram_be    = be_q[{beat_q, 2'b00} +: WORD_BE_W];
                sram_wdata = wd_q[{beat_q, 5'b0} +: WORD_W];
`ifdef LINE_MEM_WR_SKIP_EN
                sram_en    = |sram_be;
`else
                sram_en    = 1'b1;
`endif
                sram_we    = sram_en;
            end
            RD: begin
                sram_en   = 1'b1;
                sram_addr = {line_q, beat_q};
            end
            default: ;
        endcase
    end

    assign bus.o_waitrequest    = (state_q != IDLE);
    assign bus.o_readdata_valid = (state_q == RSP);
    assign bus.o_readdata       = rdata_q;
    assign o_err                = err_q;

`ifdef SIM
    a_no_dual_req : assert property (@(posedge clk) disable iff (rst)
        (state_q == IDLE) |-> !(bus.i_read && bus.i_write));
`endif

endmodule

// File: tb/tb_line_mem_bridge.sv
// ---------------------------------------------------------------------------
// tb_line_mem_bridge
// Directed bench for line_mem_bridge with a behavioural SRAM, a read
// response scoreboard (expected line + acceptance cycle queues) and a
// monitor that checks every o_readdata_valid pulse against it.
// ---------------------------------------------------------------------------
module tb_line_mem_bridge;
    import line_mem_pkg::*;

    localparam int MEM_AW = 12;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT + SRAM model ----------------
    line_mem_bridge_if #(.ADDR_W(32)) bus ();

    logic              o_err;
    logic              sram_en;
    logic              sram_we;
    logic [MEM_AW-1:0] sram_addr;
    logic [3:0]        sram_be;
    logic [31:0]       sram_wdata;
    logic [31:0]       sram_rdata;

    line_mem_bridge #(.ADDR_W(32), .LINE_W(128), .MEM_AW(MEM_AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .o_err      (o_err),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_be    (sram_be),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    logic [31:0] mem [0:(1<<MEM_AW)-1];

    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we) begin
                for (int b = 0; b < 4; b++)
                    if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    // ---------------- scoreboard state ----------------
    logic [127:0] exp_q[$];
    int           lat_q[$];
    int           n_vec = 0;
    int           n_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    logic         prev_valid = 1'b0;
    logic [127:0] prev_line  = '0;
    logic         b2b_on     = 1'b0;
    logic         b2b_prev   = 1'b0;
    int           b2b_cyc    = 0;

    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (prev_valid) begin
                check("wait_low_after_valid", {127'b0, bus.o_waitrequest}, 128'd0);
                check("readdata_hold", bus.o_readdata, prev_line);
            end
            prev_valid = bus.o_readdata_valid;
            if (bus.o_readdata_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_valid: got line %h expected no pulse", bus.o_readdata);
                end else begin
                    prev_line = exp_q.pop_front();
                    check("read_line", bus.o_readdata, prev_line);
                    check("read_latency", 128'(cyc - lat_q.pop_front()), 128'd6);
                end
                if (b2b_on) begin
                    if (b2b_prev) check("b2b_gap", 128'(cyc - b2b_cyc), 128'd7);
                    b2b_prev = 1'b1;
                    b2b_cyc  = cyc;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    logic [3:0]        wr_be_log   [4];
    logic [MEM_AW-1:0] wr_addr_log [4];

    task automatic bus_read(input logic [31:0] addr, input logic [127:0] exp, input bit keep);
        int t = 0;
        @(negedge clk);
        bus.i_addr = addr;
        bus.i_read = 1'b1;
        while (bus.o_waitrequest && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("read_accept_timeout", 128'd1, 128'd0);
        exp_q.push_back(exp);
        lat_q.push_back(cyc);
        @(posedge clk);
        @(negedge clk);
        if (!keep) bus.i_read = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [15:0] be,
                             input logic [127:0] wd, input bit dual,
                             output int busy, output int en_cnt);
        int t = 0;
        busy   = 0;
        en_cnt = 0;
        @(negedge clk);
        bus.i_addr      = addr;
        bus.i_byte_en   = be;
        bus.i_writedata = wd;
        bus.i_write     = 1'b1;
        bus.i_read      = dual;
        while (bus.o_waitrequest && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("write_accept_timeout", 128'd1, 128'd0);
        @(posedge clk);
        @(negedge clk);
        bus.i_write = 1'b0;
        bus.i_read  = 1'b0;
        while (bus.o_waitrequest && busy < 20) begin
            if (busy < 4) begin
                wr_be_log[busy]   = sram_be;
                wr_addr_log[busy] = sram_addr;
            end
            if (sram_en) en_cnt++;
            busy++;
            @(negedge clk);
        end
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("drain_empty", 128'(exp_q.size()), 128'd0);
    endtask

    // ---------------- stimulus ----------------
    localparam logic [127:0] D1 = 128'h33333333_22222222_11111111_00000000;
    localparam logic [127:0] P1 = 128'h33333333_22222222_AAAAAAAA_00000000;
    localparam logic [127:0] D2 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    localparam logic [127:0] D3 = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;

    int busy, en_cnt, skip_en_exp;

    initial begin
`ifdef LINE_MEM_WR_SKIP_EN
        skip_en_exp = 1;
`else
        skip_en_exp = 4;
`endif
        bus.i_addr = '0; bus.i_byte_en = '0; bus.i_writedata = '0;
        bus.i_read = 1'b0; bus.i_write = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_waitrequest", {127'b0, bus.o_waitrequest}, 128'd0);
        check("rst_valid",       {127'b0, bus.o_readdata_valid}, 128'd0);
        check("rst_readdata",    bus.o_readdata, 128'd0);
        check("rst_err",         {127'b0, o_err}, 128'd0);
        check("rst_sram_en",     {127'b0, sram_en}, 128'd0);
        rst = 1'b0;

        // Full line write, then read it back.
        bus_write(32'h0000_0040, 16'hFFFF, D1, 1'b0, busy, en_cnt);
        check("wr_busy",   128'(busy), 128'd4);
        check("wr_en_cnt", 128'(en_cnt), 128'd4);
        check("wr_addr0",  128'(wr_addr_log[0]), 128'h010);
        check("wr_addr3",  128'(wr_addr_log[3]), 128'h013);
        check("mem10", 128'(mem[12'h010]), 128'h00000000);
        check("mem11", 128'(mem[12'h011]), 128'h11111111);
        check("mem12", 128'(mem[12'h012]), 128'h22222222);
        check("mem13", 128'(mem[12'h013]), 128'h33333333);
        bus_read(32'h0000_0040, D1, 1'b0);
        drain();

        // Partial write touching word 1 only.
        bus_write(32'h0000_0040, 16'h00F0, {16{8'hAA}}, 1'b0, busy, en_cnt);
        check("pw_busy",   128'(busy), 128'd4);
        check("pw_en_cnt", 128'(en_cnt), 128'(skip_en_exp));
        check("pw_be1",    128'(wr_be_log[1]), 128'hF);
        check("pw_be0",    128'(wr_be_log[0]), 128'h0);
        check("pw_mem10",  128'(mem[12'h010]), 128'h00000000);
        check("pw_mem11",  128'(mem[12'h011]), 128'hAAAAAAAA);
        check("pw_mem12",  128'(mem[12'h012]), 128'h22222222);
        bus_read(32'h0000_0040, P1, 1'b0);
        drain();

        // Read and write together: write wins, no response, sticky error.
        bus_write(32'h0000_0080, 16'hFFFF, D2, 1'b1, busy, en_cnt);
        repeat (10) @(negedge clk);
        check("dual_err",   {127'b0, o_err}, 128'd1);
        check("dual_mem20", 128'(mem[12'h020]), 128'h76543210);
        check("dual_mem23", 128'(mem[12'h023]), 128'h01234567);
        bus_write(32'h0000_00C0, 16'hFFFF, D3, 1'b0, busy, en_cnt);
        check("err_sticky", {127'b0, o_err}, 128'd1);

        // Reset during read beat 2: everything clears at once.
        @(negedge clk);
        bus.i_addr = 32'h0000_0040;
        bus.i_read = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.i_read = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_waitrequest", {127'b0, bus.o_waitrequest}, 128'd0);
        check("arst_valid",       {127'b0, bus.o_readdata_valid}, 128'd0);
        check("arst_readdata",    bus.o_readdata, 128'd0);
        check("arst_err",         {127'b0, o_err}, 128'd0);
        check("arst_sram_en",     {127'b0, sram_en}, 128'd0);
        check("arst_sram_addr",   128'(sram_addr), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        bus_read(32'h0000_0040, P1, 1'b0);
        drain();

        // Back-to-back reads with read held high across three lines.
        b2b_on = 1'b1;
        bus_read(32'h0000_0040, P1, 1'b1);
        bus_read(32'h0000_0080, D2, 1'b1);
        bus_read(32'h0000_00C0, D3, 1'b0);
        drain();
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
